// File: rtl/vga_pkg.sv
// Shared constants, state/owner encodings and the cell-offset helper for the
// text-mode VRAM scheduler.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd400;
  localparam int         COLS     = 80;
  localparam int         ROWS     = 25;
  localparam int         CELL_W   = 8;
  localparam int         CELL_H   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  // row*80 + col, built from shifts so no multiplier is inferred
  function automatic logic [15:0] cell_offset(input logic [4:0] row, input logic [6:0] col);
    logic [15:0] r;
    r = {11'd0, row};
    return (r << 6) + (r << 4) + {9'd0, col};
  endfunction

endpackage

// File: rtl/vga_vram_sched_if.sv
// CPU-side access bus of the VRAM scheduler: request/ack handshake plus read return.
interface vga_vram_sched_if #(
  parameter int ADDR_W = 12
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic              cpu_ack;
  logic [15:0]       cpu_rdata;
  logic              cpu_rvalid;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_rvalid
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_rvalid
  );

endinterface

// File: rtl/vga_text_addr_gen.sv
// Maps the pixel counters to a display fetch strobe and the word address of the
// character cell under the beam.
module vga_text_addr_gen
  import vga_pkg::*;
#(
  parameter int              ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] TEXT_BASE = '0
) (
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  output logic              disp_hit,
  output logic [ADDR_W-1:0] cell_addr
);

  logic [4:0]  row;
  logic [6:0]  col;
  logic [15:0] sum;

  always_comb begin
    row       = counter_y[8:4];
    col       = counter_x[9:3];
    disp_hit  = (counter_y < V_ACTIVE) && (counter_x < H_ACTIVE) && (counter_x[2:0] == 3'd0);
    sum       = 16'(TEXT_BASE) + cell_offset(row, col);
    cell_addr = sum[ADDR_W-1:0];
  end

endmodule

// File: rtl/vga_vram_sched.sv
// Shares one synchronous single-port VRAM between the display cell fetch
// (fixed-phase, strict priority) and the CPU bus (all remaining slots).
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | CPU may be granted in any slot the display does not claim
//  ST_HOLD | ack cycle of a CPU grant; requester drops cpu_req, no grant
module vga_vram_sched
  import vga_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] TEXT_BASE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  vga_vram_sched_if.slave   cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic [15:0]       disp_data,
  output logic              disp_valid
);

  sched_state_t      state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            rd_owner_q;
  logic              disp_hit;
  logic [ADDR_W-1:0] cell_addr;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              ack_q, ack_d;

  vga_text_addr_gen #(
    .ADDR_W    (ADDR_W),
    .TEXT_BASE (TEXT_BASE)
  ) u_addr_gen (
    .counter_x (counter_x),
    .counter_y (counter_y),
    .disp_hit  (disp_hit),
    .cell_addr (cell_addr)
  );

  always_comb begin
    state_d = state_q;
    owner_d = OWN_NONE;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    ack_d   = 1'b0;

    if (state_q == ST_HOLD) begin
      state_d = ST_IDLE;
    end

    if (disp_hit) begin
      owner_d = OWN_DISP;
      addr_d  = cell_addr;
    end else if (cpu.cpu_req && (state_q == ST_IDLE)) begin
      owner_d = OWN_CPU;
      addr_d  = cpu.cpu_addr;
      we_d    = cpu.cpu_we;
      wdata_d = cpu.cpu_wdata;
      ack_d   = 1'b1;
      state_d = ST_HOLD;
    end
  end

  // rd_owner_q marks the cycle in which ram_rdata carries the slot's read data;
  // writes never produce a return
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      rd_owner_q <= OWN_NONE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rd_owner_q <= we_q ? OWN_NONE : owner_q;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
    end
  end

  assign ram_addr       = addr_q;
  assign ram_we         = we_q;
  assign ram_wdata      = wdata_q;
  assign cpu.cpu_ack    = ack_q;
  assign cpu.cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign cpu.cpu_rdata  = (rd_owner_q == OWN_CPU) ? ram_rdata : 16'h0000;
  assign disp_valid     = (rd_owner_q == OWN_DISP);
  assign disp_data      = (rd_owner_q == OWN_DISP) ? ram_rdata : 16'h0000;

endmodule
